// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg : shared types and constants for the instruction loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int          BYTES_PER_WORD = 4;
   localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

   // Big-endian placement: byte position 0 lands in the most significant lane.
   function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                               input logic [1:0]  pos,
                                               input logic [7:0]  b);
      logic [31:0] r;
      r = word;
      case (pos)
         2'd0:    r[31:24] = b;
         2'd1:    r[23:16] = b;
         2'd2:    r[15:8]  = b;
         default: r[7:0]   = b;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer : packs accepted bytes MSB-first into 32-bit words, NOP-padded
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        accept,
   input  logic        last,
   output logic        word_valid,
   output logic [31:0] word,
   output logic        partial
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;

   always_comb begin
      // Starting a fresh word from NOP_WORD leaves unfilled lanes as padding.
      word       = insert_byte((cnt_q == 2'd0) ? NOP_WORD : acc_q, cnt_q, byte_in);
      word_valid = accept && (last || (cnt_q == 2'(BYTES_PER_WORD - 1)));
      partial    = word_valid && (cnt_q != 2'(BYTES_PER_WORD - 1));
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      if (clear || word_valid) begin
         cnt_d = 2'd0;
         acc_d = NOP_WORD;
      end else if (accept) begin
         cnt_d = cnt_q + 2'd1;
         acc_d = word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         acc_q <= NOP_WORD;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader : streams a big-endian byte program into instruction memory
// Optional: IMEM_LOADER_CKSUM_EN adds an 8-bit running sum output (cksum).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WIDX_W      = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [31:0]       imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              pc_hold,
   output logic              load_done,
   output logic [WIDX_W-1:0] words_loaded,
   output logic              err_partial,
   output logic              err_overflow
`ifdef IMEM_LOADER_CKSUM_EN
   ,
   output logic [7:0]        cksum
`endif
);

   state_e             state_q, state_d;
   logic [WIDX_W-1:0]  word_idx_q, word_idx_d;
   logic               we_q, we_d;
   logic [31:0]        waddr_q, waddr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               done_q, done_d;
   logic               errp_q, errp_d;
   logic               erro_q, erro_d;

   logic               accept;
   logic               begin_load;
   logic               last_word;
   logic               pk_valid;
   logic [31:0]        pk_word;
   logic               pk_partial;

   assign accept     = byte_valid && byte_ready;
   assign begin_load = (state_q == ST_IDLE) && start;
   assign last_word  = (word_idx_q == WIDX_W'(DEPTH_WORDS - 1));

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (reset),
      .clear      (begin_load),
      .byte_in    (byte_in),
      .accept     (accept),
      .last       (byte_last),
      .word_valid (pk_valid),
      .word       (pk_word),
      .partial    (pk_partial)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: if (pk_valid && (byte_last || last_word)) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      byte_ready = (state_q == ST_LOAD);
      pc_hold    = (state_q != ST_IDLE);
   end

   // The write, address increment and DONE entry all share the handshake edge.
   always_comb begin
      we_d       = pk_valid;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      word_idx_d = word_idx_q;
      done_d     = (state_q == ST_LOAD) && (state_d == ST_DONE);
      errp_d     = errp_q;
      erro_d     = erro_q;
      if (begin_load) begin
         word_idx_d = '0;
         errp_d     = 1'b0;
         erro_d     = 1'b0;
      end
      if (pk_valid) begin
         waddr_d    = 32'({word_idx_q, 2'b00});
         wdata_d    = pk_word;
         word_idx_d = word_idx_q + 1'b1;
         if (pk_partial) errp_d = 1'b1;
         if (last_word && !byte_last) erro_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_idx_q <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         errp_q     <= 1'b0;
         erro_q     <= 1'b0;
      end else begin
         word_idx_q <= word_idx_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         errp_q     <= errp_d;
         erro_q     <= erro_d;
      end
   end

   assign imem_we      = we_q;
   assign imem_waddr   = waddr_q;
   assign imem_wdata   = wdata_q;
   assign load_done    = done_q;
   assign words_loaded = word_idx_q;
   assign err_partial  = errp_q;
   assign err_overflow = erro_q;

`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0] cksum_q, cksum_d;

   always_comb begin
      cksum_d = cksum_q;
      if (begin_load) cksum_d = 8'h00;
      else if (accept) cksum_d = cksum_q + byte_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cksum_q <= 8'h00;
      end else begin
         cksum_q <= cksum_d;
      end
   end

   assign cksum = cksum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader : table-driven and randomized checks of imem_loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

   localparam int DEPTH = 4;
   localparam int WW    = 3;
   localparam int CAP   = 4 * DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid = 1'b0;
   logic          byte_last = 1'b0;
   logic          byte_ready;
   logic          imem_we;
   logic [31:0]   imem_waddr;
   logic [31:0]   imem_wdata;
   logic          pc_hold;
   logic          load_done;
   logic [WW-1:0] words_loaded;
   logic          err_partial;
   logic          err_overflow;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0]    cksum;
`endif

   imem_loader #(.DEPTH_WORDS(DEPTH), .WIDX_W(WW)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .start        (start),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_last    (byte_last),
      .byte_ready   (byte_ready),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .pc_hold      (pc_hold),
      .load_done    (load_done),
      .words_loaded (words_loaded),
      .err_partial  (err_partial),
      .err_overflow (err_overflow)
`ifdef IMEM_LOADER_CKSUM_EN
      ,
      .cksum        (cksum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write monitor: records every strobe, checks load_done rides with the final write.
   logic [31:0] act_addr[$];
   logic [31:0] act_data[$];
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (imem_we) begin
         act_addr.push_back(imem_waddr);
         act_data.push_back(imem_wdata);
      end
      if (load_done) begin
         done_cnt++;
         check("done_with_we", {31'd0, imem_we}, 32'd1);
      end
   end

   // Reference model: the byte stream chopped into big-endian words.
   logic [7:0]  stim[$];
   logic [31:0] exp_data[$];

   task automatic model(input bit has_last, output int nacc, output int words,
                        output bit part, output bit ovf, output logic [7:0] ck);
      int n;
      n     = stim.size();
      nacc  = (n < CAP) ? n : CAP;
      words = (nacc + 3) / 4;
      part  = has_last && (n <= CAP) && ((n % 4) != 0);
      ovf   = !(has_last && (n <= CAP));
      ck    = 8'h00;
      exp_data.delete();
      for (int i = 0; i < nacc; i++) begin
         if (i % 4 == 0) exp_data.push_back(32'h0);
         exp_data[i/4] = exp_data[i/4] | (32'(stim[i]) << (24 - 8 * (i % 4)));
         ck = ck + stim[i];
      end
   endtask

   task automatic run_load(input bit has_last, input bit b2b);
      int         n, nacc, words, budget;
      bit         part, ovf, stuck;
      logic [7:0] ck;
      n = stim.size();
      model(has_last, nacc, words, part, ovf, ck);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      act_addr.delete();
      act_data.delete();
      done_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("load_pc_hold", {31'd0, pc_hold}, 32'd1);
      check("load_cleared", {27'd0, words_loaded, err_partial, err_overflow}, 32'd0);
      stuck = 1'b0;
      for (int i = 0; i < nacc && !stuck; i++) begin
         if (!b2b) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         byte_in    = stim[i];
         byte_valid = 1'b1;
         byte_last  = has_last && (i == n - 1);
         start      = !b2b && ($urandom_range(0, 3) == 0);
         if (b2b) check("b2b_ready", {31'd0, byte_ready}, 32'd1);
         budget = 0;
         while (!byte_ready && budget < 20) begin @(posedge clk); #1; budget++; end
         if (!byte_ready) begin
            check("ready_timeout", {31'd0, byte_ready}, 32'd1);
            stuck = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      // DONE cycle; extra bytes after an overflow must be refused.
      byte_valid = (n > nacc);
      byte_last  = 1'b0;
      byte_in    = 8'h5A;
      start      = !b2b;
      check("done_pulse", {31'd0, load_done}, 32'd1);
      check("done_pc_hold", {31'd0, pc_hold}, 32'd1);
      check("done_ready", {31'd0, byte_ready}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_pc_hold", {31'd0, pc_hold}, 32'd0);
      check("idle_done_low", {31'd0, load_done}, 32'd0);
      repeat (3) begin
         check("idle_ready", {31'd0, byte_ready}, 32'd0);
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      check("write_count", act_addr.size(), words);
      for (int w = 0; w < words && w < act_addr.size(); w++) begin
         check("waddr", act_addr[w], w * 4);
         check("wdata", act_data[w], exp_data[w]);
      end
      check("words_loaded", 32'(words_loaded), words);
      check("err_partial", {31'd0, err_partial}, {31'd0, part});
      check("err_overflow", {31'd0, err_overflow}, {31'd0, ovf});
      check("done_count", done_cnt, 1);
`ifdef IMEM_LOADER_CKSUM_EN
      check("cksum", {24'd0, cksum}, {24'd0, ck});
`endif
   endtask

   typedef struct {
      logic [7:0] first;
      int         n;
      bit         has_last;
      bit         b2b;
      int         exp_words;
      bit         exp_part;
      bit         exp_ovf;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h10, 12, 1'b1, 1'b1, 3, 1'b0, 1'b0};
      vecs[1] = '{8'h30, 20, 1'b0, 1'b1, 4, 1'b0, 1'b1};
      vecs[2] = '{8'h40, 16, 1'b1, 1'b1, 4, 1'b0, 1'b0};
      vecs[3] = '{8'h77,  1, 1'b1, 1'b0, 1, 1'b1, 1'b0};
      vecs[4] = '{8'h50, 16, 1'b0, 1'b0, 4, 1'b0, 1'b1};
      vecs[5] = '{8'h60,  7, 1'b1, 1'b0, 2, 1'b1, 1'b0};
      vecs[6] = '{8'h80, 18, 1'b1, 1'b0, 4, 1'b0, 1'b1};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {26'd0, byte_ready, imem_we, pc_hold, load_done, err_partial, err_overflow}, 32'd0);
      check("rst_waddr", imem_waddr, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Bytes offered in IDLE are refused.
      byte_valid = 1'b1;
      byte_in    = 8'hEE;
      repeat (3) begin
         check("idle_ignore_ready", {31'd0, byte_ready}, 32'd0);
         @(posedge clk); #1;
      end
      check("idle_no_write", act_addr.size(), 0);

      stim = '{8'h20, 8'h08, 8'h00, 8'h05};
      run_load(1'b1, 1'b1);
      check("single_word", act_data[0], 32'h2008_0005);

      stim = '{8'hFF, 8'h02, 8'h01, 8'h00};
      run_load(1'b1, 1'b0);
`ifdef IMEM_LOADER_CKSUM_EN
      check("cksum_fixed", {24'd0, cksum}, 32'h02);
`endif

      stim = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
      run_load(1'b1, 1'b0);
      check("partial_wdata", act_data[1], 32'hAEAF_0000);
      check("partial_waddr", act_addr[1], 32'd4);

      for (int v = 0; v < 7; v++) begin
         stim.delete();
         for (int i = 0; i < vecs[v].n; i++) stim.push_back(vecs[v].first + 8'(i));
         run_load(vecs[v].has_last, vecs[v].b2b);
         check("tbl_words", 32'(words_loaded), vecs[v].exp_words);
         check("tbl_flags", {30'd0, err_partial, err_overflow},
               {30'd0, vecs[v].exp_part, vecs[v].exp_ovf});
      end

      // Reset in the middle of a word: nothing may be written.
      act_addr.delete();
      act_data.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      byte_valid = 1'b1;
      byte_in    = 8'h11;
      @(posedge clk); #1;
      byte_in    = 8'h22;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", {26'd0, byte_ready, imem_we, pc_hold, load_done, err_partial, err_overflow}, 32'd0);
      check("midrst_wdata", imem_wdata, 32'd0);
      check("midrst_waddr", imem_waddr, 32'd0);
      check("midrst_words", 32'(words_loaded), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_no_write", act_addr.size(), 0);
      stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_load(1'b1, 1'b0);

      for (int r = 0; r < 12; r++) begin
         bit hl;
         int n;
         hl = ($urandom_range(0, 1) == 1);
         n  = hl ? int'($urandom_range(1, CAP + 4)) : int'($urandom_range(CAP, CAP + 4));
         stim.delete();
         for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
         run_load(hl, ($urandom_range(0, 1) == 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
